bcd_digit_encoder: RTL
======================

Name: bcd_digit_encoder

Overview:
- Sequential binary-to-BCD encoder (shift-add-3, one bit per clock). It converts the signed product of the SPM datapath into five BCD digits plus a sign flag.
- It is the producer for the display digit window. It drives the D0..D4 digit bus that the window selector consumes and scrolls, and it supplies the digit-count information the scroll logic needs.
- Results are held stable between conversions, so the display never shows partial values.

Parameters:
- WIDTH, 16, width of the signed two's-complement input product.
- NDIG, 5, number of BCD digits produced. Must satisfy 10^NDIG > 2^(WIDTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset, asynchronous, active-high.
- start  in  1  request a conversion of prod. Sampled only in IDLE.
- prod  in  WIDTH  signed product to encode. Sampled only on the accepting edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: new result on the outputs.
- neg  out  1  sign of the last converted product (1 = negative).
- D0  out  4  BCD units digit (least significant).
- D1, D2, D3  out  4 each  BCD tens, hundreds and thousands digits.
- D4  out  4  BCD ten-thousands digit (most significant).
- msd_idx  out  3  index of the most significant non-zero digit. 0 when the value is 0.

Behaviour:
- Reset (R=1, asynchronous): state=IDLE; busy=0, done=0, neg=0, D0..D4=0, msd_idx=0; work registers and iteration counter cleared. Reset mid-conversion aborts it. No done pulse is produced, and outputs return to reset values.
- States: IDLE, CONV.
- IDLE: if start=1 at edge E0, the block does the following at E0:
  - magnitude <= (prod[WIDTH-1] ? -prod : prod), computed as an unsigned WIDTH-bit value. -32768 gives 32768 with no overflow.
  - sign_work <= prod[WIDTH-1]; bcd_work <= 0; cnt <= 0; state <= CONV; busy <= 1.
- CONV, each edge:
  - Every 4-bit digit of bcd_work that is >=5 gets +3 added.
  - Then {bcd_work, magnitude} is shifted left by 1.
  - cnt increments.
- Completion: the edge where cnt reaches WIDTH-1 performs the final iteration and also does the following:
  - D0..D4 <= corrected-and-shifted digits.
  - neg <= sign_work.
  - msd_idx <= highest index i with Di != 0, else 0.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: for start sampled at E0, busy is high for the cycles after E0 through E0+15. done=1 and the new outputs are valid in the cycle after E0+WIDTH (E0+16). done falls after the next edge.
- start while busy=1 is ignored (not queued). start=1 in the cycle where done=1 is accepted, so conversions can run back-to-back with no gap cycle.
- D0..D4, neg and msd_idx hold the previous result for the whole conversion. They change only on the completion edge.
- Digits are always valid BCD (0..9). No digit ever exceeds 9 for any input, including -2^(WIDTH-1).
- A zero result gives neg=0, even if the input was negative zero. Only exact 0 can produce that case, so neg=0 there.
- start and prod are synchronous to clk. No input synchronizers are required.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0 and ST_CONV=1;
  - defaults WIDTH=16 and NDIG=5;
  - BCD_CORR_THRESH=5 and BCD_CORR_ADD=3;
  - the counter width constant, clog2(WIDTH).
- One natural sub-module: bcd_add3_cell, a combinational 4-bit "if >=5 then +3" corrector. It is instantiated NDIG times in a generate loop.
- The leading-digit priority encoder for msd_idx stays inline.

Test Plan:
- Reset then idle: assert R, release, hold start=0 for 20 cycles -> all outputs 0, busy=0, done never pulses.
- prod=16'h3039 (12345), start pulse -> done exactly 16 edges after the accepting edge; D4..D0=1,2,3,4,5; neg=0; msd_idx=4; busy high for 16 cycles.
- prod=16'hFF85 (-123) -> D4..D0=0,0,1,2,3; neg=1; msd_idx=2.
- Corner inputs:
  - prod=16'h8000 (-32768) -> 3,2,7,6,8; neg=1; msd_idx=4.
  - prod=16'h7FFF -> 3,2,7,6,7; neg=0.
  - prod=0 -> all 0; neg=0; msd_idx=0.
- Protocol:
  - start re-pulsed mid-conversion with a different prod -> ignored, and the first result is reported.
  - start held in the done cycle -> second conversion accepted, and its done arrives 16 edges later.
  - Outputs stay unchanged during the second conversion.
- Abort: assert R at cycle 8 of a conversion of 12345 -> outputs go to 0 immediately (asynchronously) and no done pulse occurs. A later conversion of 42 gives 0,0,0,4,2 with msd_idx=1.

Source files
------------

// File: rtl/bcd_digit_encoder_pkg.sv
// Shared definitions for the BCD digit encoder.
//   state_t          : encoder states (ST_IDLE, ST_CONV)
//   DEF_WIDTH/NDIG   : default product width and digit count
//   BCD_CORR_*       : shift-add-3 correction threshold and increment
//   DEF_CNT_W        : iteration counter width for the default product width
package bcd_digit_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NDIG  = 5;

  localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
  localparam logic [3:0] BCD_CORR_ADD    = 4'd3;

  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

endpackage

// File: rtl/bcd_add3_cell.sv
// Combinational shift-add-3 corrector for one BCD digit.
//   i_digit : 4-bit BCD digit before the shift
//   o_digit : i_digit + 3 when i_digit >= 5, otherwise i_digit
import bcd_digit_encoder_pkg::*;

module bcd_add3_cell (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_CORR_THRESH) ? (i_digit + BCD_CORR_ADD) : i_digit;

endmodule

// File: rtl/bcd_digit_encoder.sv
// Sequential binary-to-BCD encoder (shift-add-3, one bit per clock).
// Converts a signed two's-complement product into NDIG BCD digits plus a
// sign flag. Results are held between conversions and update only on the
// completion edge.
//   clk      : system clock, rising edge
//   R        : asynchronous active-high reset
//   start    : conversion request, sampled only in IDLE
//   prod     : signed product, sampled on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle pulse, new result on the outputs
//   neg      : sign of the last converted product
//   D0..D4   : BCD digits, D0 least significant
//   msd_idx  : index of the most significant non-zero digit (0 for value 0)
import bcd_digit_encoder_pkg::*;

module bcd_digit_encoder #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NDIG  = DEF_NDIG
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] prod,
  output logic             busy,
  output logic             done,
  output logic             neg,
  output logic [3:0]       D0,
  output logic [3:0]       D1,
  output logic [3:0]       D2,
  output logic [3:0]       D3,
  output logic [3:0]       D4,
  output logic [2:0]       msd_idx
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = NDIG * 4;
  localparam int IDX_W = 3;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [BCD_W-1:0]   r_digits;
  logic               r_neg;
  logic [IDX_W-1:0]   r_msd;
  logic               r_done;

  state_t             w_nxt_state;
  logic [WIDTH-1:0]   w_nxt_mag;
  logic [BCD_W-1:0]   w_nxt_bcd;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic               w_nxt_sign;
  logic [BCD_W-1:0]   w_nxt_digits;
  logic               w_nxt_neg;
  logic [IDX_W-1:0]   w_nxt_msd;
  logic               w_nxt_done;

  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W-1:0]   w_shift_bcd;
  logic [WIDTH-1:0]   w_shift_mag;
  logic [WIDTH-1:0]   w_abs;
  logic [IDX_W-1:0]   w_msd;
  logic               w_last;

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_corr
      bcd_add3_cell u_cell (
        .i_digit (r_bcd[g*4 +: 4]),
        .o_digit (w_corr[g*4 +: 4])
      );
    end
  endgenerate

  // The full corrected vector is shifted as one unit; the top digit never
  // carries out because 10^NDIG exceeds the largest magnitude.
  assign {w_shift_bcd, w_shift_mag} = {w_corr, r_mag} << 1;

  // Unsigned negation: -2^(WIDTH-1) maps onto itself, which is the correct
  // unsigned magnitude.
  assign w_abs  = prod[WIDTH-1] ? (~prod + 1'b1) : prod;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_msd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_shift_bcd[i*4 +: 4] != 4'd0) w_msd = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_state  <= ST_IDLE;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_digits <= '0;
      r_neg    <= 1'b0;
      r_msd    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_mag    <= w_nxt_mag;
      r_bcd    <= w_nxt_bcd;
      r_cnt    <= w_nxt_cnt;
      r_sign   <= w_nxt_sign;
      r_digits <= w_nxt_digits;
      r_neg    <= w_nxt_neg;
      r_msd    <= w_nxt_msd;
      r_done   <= w_nxt_done;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_mag    = r_mag;
    w_nxt_bcd    = r_bcd;
    w_nxt_cnt    = r_cnt;
    w_nxt_sign   = r_sign;
    w_nxt_digits = r_digits;
    w_nxt_neg    = r_neg;
    w_nxt_msd    = r_msd;
    w_nxt_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_mag   = w_abs;
          w_nxt_sign  = prod[WIDTH-1];
          w_nxt_bcd   = '0;
          w_nxt_cnt   = '0;
          w_nxt_state = ST_CONV;
        end
      end
      ST_CONV: begin
        w_nxt_bcd = w_shift_bcd;
        w_nxt_mag = w_shift_mag;
        w_nxt_cnt = r_cnt + 1'b1;
        if (w_last) begin
          w_nxt_digits = w_shift_bcd;
          w_nxt_neg    = r_sign;
          w_nxt_msd    = w_msd;
          w_nxt_done   = 1'b1;
          w_nxt_state  = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign busy    = (r_state == ST_CONV);
  assign done    = r_done;
  assign neg     = r_neg;
  assign msd_idx = r_msd;
  assign D0      = r_digits[3:0];
  assign D1      = r_digits[7:4];
  assign D2      = r_digits[11:8];
  assign D3      = r_digits[15:12];
  assign D4      = r_digits[19:16];

endmodule
